op_frame_arbiter: RTL and testbench

Round-robin arbiter sharing the single operand-receive path among `NUM_REQ` requesters. Each requester delivers an operation as a `BEATS`-word frame (a, b, c low, c high). The block grants one requester per frame, locks the grant until the last beat is accepted, and forwards beats downstream with valid/ready. It sits between the requester read ports and the operand receive FSM, and publishes the granted requester ID so results can be tagged.

---
 rtl/config_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/op_frame_arbiter.sv | 89 ++++++++
 tb/tb_op_frame_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared types for the operand path: beat data word, requester IDs and arbiter FSM states.
package config_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 4;
    localparam int BEATS   = 4;

    typedef logic [DATA_W-1:0]          data_t;
    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N-1.
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt_oh,
    output logic [IDW-1:0] gnt_idx,
    output logic           any
);

    logic found;
    int   idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            // ptr < N and i < N, so one subtraction is enough to wrap
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = IDW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/op_frame_arbiter.sv
// Grants the operand-receive path to one requester per BEATS-word frame, locked until the last beat.
module op_frame_arbiter
    import config_pkg::*;
#(
    parameter  int NUM_REQ = config_pkg::NUM_REQ,
    parameter  int BEATS   = config_pkg::BEATS,
    localparam int IDW     = $clog2(NUM_REQ),
    localparam int BW      = $clog2(BEATS)
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  data_t [NUM_REQ-1:0]    req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   rd_data_valid_o,
    output data_t                  rd_data_o,
    input  logic                   rd_data_ready_i,
    output logic [IDW-1:0]         gnt_id_o,
    output logic                   frame_last_o,
    output logic                   busy_o
);

    arb_state_t         state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     gnt_id_q;
    logic [NUM_REQ-1:0] gnt_oh_q;
    logic [BW-1:0]      beat_cnt;
    logic               busy_q;

    logic [NUM_REQ-1:0] arb_oh;
    logic [IDW-1:0]     arb_idx;
    logic               arb_any;
    logic               xfer;
    logic               hs;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req_valid_i),
        .ptr     (rr_ptr),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Forward path is purely combinational off the held grant
    assign xfer            = (state == XFER);
    assign rd_data_valid_o = xfer && req_valid_i[gnt_id_q];
    assign rd_data_o       = xfer ? req_data_i[gnt_id_q] : '0;
    assign req_ready_o     = (xfer && rd_data_ready_i) ? gnt_oh_q : '0;
    assign frame_last_o    = xfer && (beat_cnt == BW'(BEATS - 1));
    assign hs              = rd_data_valid_o && rd_data_ready_i;
    assign gnt_id_o        = gnt_id_q;
    assign busy_o          = busy_q;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_id_q <= '0;
            gnt_oh_q <= '0;
            beat_cnt <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt_id_q <= arb_idx;
                        gnt_oh_q <= arb_oh;
                        beat_cnt <= '0;
                        busy_q   <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (hs) begin
                        if (frame_last_o) begin
                            rr_ptr <= (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_frame_arbiter.sv
// Randomized bench for op_frame_arbiter against a frame-level round-robin reference model.
module tb_op_frame_arbiter;
    import config_pkg::*;

    localparam int N = 4;
    localparam int B = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [N-1:0]  req_valid_i;
    data_t [N-1:0] req_data_i;
    logic [N-1:0]  req_ready_o;
    logic          rd_data_valid_o;
    data_t         rd_data_o;
    logic          rd_data_ready_i;
    logic [1:0]    gnt_id_o;
    logic          frame_last_o;
    logic          busy_o;

    op_frame_arbiter #(.NUM_REQ(N), .BEATS(B)) dut (
        .clk             (clk),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .rd_data_valid_o (rd_data_valid_o),
        .rd_data_o       (rd_data_o),
        .rd_data_ready_i (rd_data_ready_i),
        .gnt_id_o        (gnt_id_o),
        .frame_last_o    (frame_last_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: frame-level view of who owns the path and which beat is due
    bit m_busy;
    int m_gnt, m_beat, m_ptr;
    int bidx[N];
    int fcnt[N];
    int mode;

    function automatic data_t word(input int r);
        return data_t'(r * 32'h0100_0000 + (fcnt[r] % 256) * 256 + bidx[r]);
    endfunction

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            req_data_i[r]  = word(r);
            req_valid_i[r] = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        end
        rd_data_ready_i = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        rst_i           = (mode == 1) && ($urandom_range(0, 299) == 0);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_gnt = 0; m_beat = 0; m_ptr = 0;
        for (int r = 0; r < N; r++) bidx[r] = 0;
    endtask

    int rot_k = 0;
    int idle_run = 0;
    bit prev_busy = 1'b0;

    task automatic check_and_step();
        logic [N-1:0] e_rdy;
        logic         e_v, e_last;
        data_t        e_d;
        int           w;
        e_rdy = '0; e_v = 1'b0; e_last = 1'b0; e_d = '0;
        if (m_busy) begin
            e_v    = req_valid_i[m_gnt];
            e_d    = word(m_gnt);
            e_rdy[m_gnt] = rd_data_ready_i;
            e_last = (m_beat == B - 1);
        end
        chk("busy",  32'(busy_o),          32'(m_busy));
        chk("gnt",   32'(gnt_id_o),        32'(m_gnt));
        chk("valid", 32'(rd_data_valid_o), 32'(e_v));
        chk("data",  rd_data_o,            e_d);
        chk("ready", 32'(req_ready_o),     32'(e_rdy));
        chk("last",  32'(frame_last_o),    32'(e_last));

        if (mode == 0) begin
            if (busy_o && !prev_busy) begin
                chk("rot_gnt", 32'(gnt_id_o), 32'(rot_k % N));
                if (rot_k > 0) chk("idle_gap", 32'(idle_run), 32'd1);
                rot_k++;
                idle_run = 0;
            end else if (!busy_o) begin
                idle_run++;
            end
        end
        prev_busy = busy_o;

        // Advance model for the coming edge
        if (rst_i) begin
            model_reset();
        end else if (!m_busy) begin
            if (|req_valid_i) begin
                for (int k = N - 1; k >= 0; k--) begin
                    w = (m_ptr + k) % N;
                    if (req_valid_i[w]) m_gnt = w;
                end
                m_busy = 1'b1;
                m_beat = 0;
            end
        end else if (req_valid_i[m_gnt] && rd_data_ready_i) begin
            if (m_beat == B - 1) begin
                bidx[m_gnt] = 0;
                fcnt[m_gnt]++;
                m_ptr  = (m_gnt + 1) % N;
                m_busy = 1'b0;
            end else begin
                bidx[m_gnt]++;
                m_beat++;
            end
        end
    endtask

    initial begin
        for (int r = 0; r < N; r++) fcnt[r] = 0;
        model_reset();
        mode            = 0;
        rst_i           = 1'b1;
        req_valid_i     = '0;
        req_data_i      = '0;
        rd_data_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i       = 1'b0;
        req_valid_i = '0;
        @(negedge clk);
        chk("rst_busy",  32'(busy_o),          32'd0);
        chk("rst_gnt",   32'(gnt_id_o),        32'd0);
        chk("rst_valid", 32'(rd_data_valid_o), 32'd0);
        chk("rst_data",  rd_data_o,            32'd0);
        chk("rst_ready", 32'(req_ready_o),     32'd0);
        @(posedge clk);
        #1;

        // All requesters valid, no backpressure: grants must rotate with a single idle bubble
        drive();
        for (int c = 0; c < 41; c++) begin
            @(negedge clk);
            check_and_step();
            @(posedge clk);
            #1;
            drive();
        end
        chk("rot_count", 32'(rot_k >= 8), 32'd1);

        mode = 1;
        drive();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            check_and_step();
            @(posedge clk);
            #1;
            drive();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
